// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared widths, MEM-stage state encoding and MEM/WB bubble value
// Rev 1.0
// ============================================================================
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_src;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, pc_src: 1'b0};

endpackage
`default_nettype wire

// File: rtl/mem_wb_buffer.sv
`default_nettype none
// ============================================================================
// mem_wb_buffer : MEM/WB pipeline register; loads the stage result or a bubble
// Rev 1.0
// ============================================================================
module mem_wb_buffer #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  mips_pkg::wb_ctrl_t ctrl_in,
    input  logic [DATA_W-1:0]  read_data_in,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [REG_W-1:0]   write_reg_in,
    output mips_pkg::wb_ctrl_t ctrl_out,
    output logic [DATA_W-1:0]  read_data_out,
    output logic [DATA_W-1:0]  alu_result_out,
    output logic [REG_W-1:0]   write_reg_out
);
    import mips_pkg::*;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_out       <= '0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            write_reg_out  <= '0;
        end else if (load) begin
            ctrl_out       <= ctrl_in;
            read_data_out  <= read_data_in;
            alu_result_out <= alu_result_in;
            write_reg_out  <= write_reg_in;
        end else begin
            ctrl_out       <= WB_CTRL_BUBBLE;
            read_data_out  <= '0;
            alu_result_out <= '0;
            write_reg_out  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// mem_stage_ctrl : MEM stage with req/ready data-memory port, stall and abort.
// Optional MEM_ALIGN_CHECK_EN rejects word-misaligned accesses. Rev 1.0
// ============================================================================
module mem_stage_ctrl #(
    parameter int DATA_W      = mips_pkg::DATA_W,
    parameter int REG_W       = mips_pkg::REG_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              Branch_in,
    input  logic              Zero_in,
    input  logic [DATA_W-1:0] ALU_Result_in,
    input  logic [DATA_W-1:0] StoreData_in,
    input  logic [REG_W-1:0]  WriteReg_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_out,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic [DATA_W-1:0] ReadData_out,
    output logic [DATA_W-1:0] ALU_Result_out,
    output logic [REG_W-1:0]  WriteReg_out,
    output logic              PCSrc_out,
    output logic              bus_err_out
);
    import mips_pkg::*;

    localparam int                CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic               mem_op;
    logic               misaligned;
    logic               issue;
    logic               finish;
    logic               abort;
    logic               wait_inc;
    logic               wb_load;
    logic               align_err;
    logic               stall;
    wb_ctrl_t           wb_ctrl_in;
    wb_ctrl_t           wb_ctrl_q;
    logic [DATA_W-1:0]  wb_read_data;

    assign mem_op = MemRead_in | MemWrite_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op && (ALU_Result_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        wait_inc   = 1'b0;
        wb_load    = 1'b0;
        align_err  = 1'b0;
        stall      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (misaligned) begin
                    align_err = 1'b1;
                end else if (mem_op) begin
                    stall      = 1'b1;
                    issue      = 1'b1;
                    state_next = ST_ACCESS;
                end else begin
                    wb_load = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (dmem_ready) begin
                    wb_load    = 1'b1;
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Give up: the instruction leaves as a bubble and upstream is released
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    stall    = 1'b1;
                    wait_inc = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset forces every output low, including the combinational stall
    assign stall_out = stall & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            bus_err_out <= 1'b0;
        end else begin
            state       <= state_next;
            bus_err_out <= abort | align_err;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= MemWrite_in;
                dmem_addr  <= ALU_Result_in;
                dmem_wdata <= StoreData_in;
            end else if (finish || abort) begin
                dmem_req <= 1'b0;
            end
            if (issue || finish || abort) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign wb_ctrl_in   = '{reg_write: RegWrite_in, mem_to_reg: MemToReg_in,
                            pc_src: Branch_in & Zero_in};
    assign wb_read_data = ((state == ST_ACCESS) && !dmem_we) ? dmem_rdata : '0;

    mem_wb_buffer #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clk            (clk),
        .reset_n        (reset_n),
        .load           (wb_load),
        .ctrl_in        (wb_ctrl_in),
        .read_data_in   (wb_read_data),
        .alu_result_in  (ALU_Result_in),
        .write_reg_in   (WriteReg_in),
        .ctrl_out       (wb_ctrl_q),
        .read_data_out  (ReadData_out),
        .alu_result_out (ALU_Result_out),
        .write_reg_out  (WriteReg_out)
    );

    assign RegWrite_out = wb_ctrl_q.reg_write;
    assign MemToReg_out = wb_ctrl_q.mem_to_reg;
    assign PCSrc_out    = wb_ctrl_q.pc_src;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_ctrl : directed self-checking bench for mem_stage_ctrl
// Rev 1.0
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TO = 64;

    logic          clk;
    logic          reset_n;
    logic          RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, Branch_in, Zero_in;
    logic [DW-1:0] ALU_Result_in, StoreData_in;
    logic [RW-1:0] WriteReg_in;
    logic          dmem_req, dmem_we, dmem_ready;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          stall_out, RegWrite_out, MemToReg_out, PCSrc_out, bus_err_out;
    logic [DW-1:0] ReadData_out, ALU_Result_out;
    logic [RW-1:0] WriteReg_out;

    int checks;
    int errors;
    int req_cnt, stall_cnt, rd_cnt, pc_cnt, err_cnt;

    mem_stage_ctrl #(
        .DATA_W      (DW),
        .REG_W       (RW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .RegWrite_in    (RegWrite_in),
        .MemToReg_in    (MemToReg_in),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .Branch_in      (Branch_in),
        .Zero_in        (Zero_in),
        .ALU_Result_in  (ALU_Result_in),
        .StoreData_in   (StoreData_in),
        .WriteReg_in    (WriteReg_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .stall_out      (stall_out),
        .RegWrite_out   (RegWrite_out),
        .MemToReg_out   (MemToReg_out),
        .ReadData_out   (ReadData_out),
        .ALU_Result_out (ALU_Result_out),
        .WriteReg_out   (WriteReg_out),
        .PCSrc_out      (PCSrc_out),
        .bus_err_out    (bus_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        RegWrite_in   = 1'b0;
        MemToReg_in   = 1'b0;
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        Branch_in     = 1'b0;
        Zero_in       = 1'b0;
        ALU_Result_in = '0;
        StoreData_in  = '0;
        WriteReg_in   = '0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        clear_inputs();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_regwrite", RegWrite_out, 0);
        chk("rst_readdata", ReadData_out, 0);
        chk("rst_pcsrc", PCSrc_out, 0);
        chk("rst_buserr", bus_err_out, 0);
        reset_n = 1'b1;

        // ALU op passes through in one cycle
        @(negedge clk);
        RegWrite_in   = 1'b1;
        ALU_Result_in = 32'h10;
        WriteReg_in   = 5'd5;
        #1;
        chk("add_stall", stall_out, 0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("add_regwrite", RegWrite_out, 1);
        chk("add_alu", ALU_Result_out, 32'h10);
        chk("add_wreg", WriteReg_out, 5);
        chk("add_stall2", stall_out, 0);

        // Branch resolution
        Branch_in = 1'b1;
        Zero_in   = 1'b1;
        @(negedge clk);
        Zero_in = 1'b0;
        #1;
        chk("br_taken", PCSrc_out, 1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("br_not_taken", PCSrc_out, 0);

        // Load at 0x100, three wait cycles, stalled branch must not fire
        @(negedge clk);
        MemRead_in    = 1'b1;
        RegWrite_in   = 1'b1;
        MemToReg_in   = 1'b1;
        ALU_Result_in = 32'h100;
        WriteReg_in   = 5'd7;
        Branch_in     = 1'b1;
        Zero_in       = 1'b1;
        req_cnt = 0; stall_cnt = 0; rd_cnt = 0; pc_cnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dmem_ready = (cyc == 4);
            dmem_rdata = (cyc == 4) ? 32'hDEADBEEF : 32'hBAD00BAD;
            if (cyc == 5) clear_inputs();
            #1;
            req_cnt   += int'(dmem_req);
            stall_cnt += int'(stall_out);
            rd_cnt    += int'(ReadData_out == 32'hDEADBEEF);
            if (cyc >= 1 && cyc <= 4) pc_cnt += int'(PCSrc_out);
            if (cyc == 1) begin
                chk("ld_addr", dmem_addr, 32'h100);
                chk("ld_we", dmem_we, 0);
                chk("ld_bubble", RegWrite_out, 0);
            end
            if (cyc == 5) begin
                chk("ld_req_drop", dmem_req, 0);
                chk("ld_regwrite", RegWrite_out, 1);
                chk("ld_memtoreg", MemToReg_out, 1);
                chk("ld_alu", ALU_Result_out, 32'h100);
                chk("ld_wreg", WriteReg_out, 7);
                chk("ld_pcsrc", PCSrc_out, 1);
            end
        end
        chk("ld_req_cycles", req_cnt, 4);
        chk("ld_stall_cycles", stall_cnt, 4);
        chk("ld_rdata_once", rd_cnt, 1);
        chk("ld_stalled_pcsrc", pc_cnt, 0);

        // Store, ready on first ACCESS cycle
        @(negedge clk);
        MemWrite_in   = 1'b1;
        ALU_Result_in = 32'h20;
        StoreData_in  = 32'h55AA;
        WriteReg_in   = 5'd3;
        #1;
        chk("st_stall_idle", stall_out, 1);
        @(negedge clk);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h77777777;
        #1;
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_wdata", dmem_wdata, 32'h55AA);
        chk("st_addr", dmem_addr, 32'h20);
        chk("st_stall_ready", stall_out, 0);
        @(negedge clk);
        dmem_ready = 1'b0;
        clear_inputs();
        #1;
        chk("st_req_drop", dmem_req, 0);
        chk("st_regwrite", RegWrite_out, 0);
        chk("st_readdata", ReadData_out, 0);
        chk("st_alu", ALU_Result_out, 32'h20);

        // Read and write together behave as a write
        MemRead_in    = 1'b1;
        MemWrite_in   = 1'b1;
        ALU_Result_in = 32'h30;
        StoreData_in  = 32'hA5;
        @(negedge clk);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        #1;
        chk("rw_we", dmem_we, 1);
        @(negedge clk);
        dmem_ready = 1'b0;
        clear_inputs();
        #1;
        chk("rw_readdata", ReadData_out, 0);

        // Load never acknowledged: timeout abort
        MemRead_in    = 1'b1;
        RegWrite_in   = 1'b1;
        ALU_Result_in = 32'h40;
        WriteReg_in   = 5'd4;
        #1;
        chk("to_stall_idle", stall_out, 1);
        req_cnt = 0; stall_cnt = 0; err_cnt = 0;
        for (int cyc = 1; cyc <= TO + 2; cyc++) begin
            @(negedge clk);
            #1;
            req_cnt   += int'(dmem_req);
            stall_cnt += int'(stall_out);
            err_cnt   += int'(bus_err_out);
            if (cyc == TO) begin
                chk("to_stall_last", stall_out, 0);
                clear_inputs();
            end
            if (cyc == TO + 1) begin
                chk("to_req_drop", dmem_req, 0);
                chk("to_buserr", bus_err_out, 1);
                chk("to_regwrite", RegWrite_out, 0);
            end
        end
        chk("to_req_cycles", req_cnt, TO);
        chk("to_stall_cycles", stall_cnt, TO - 1);
        chk("to_err_pulses", err_cnt, 1);

        // Back in IDLE: plain op flows with no stall
        RegWrite_in   = 1'b1;
        ALU_Result_in = 32'h5;
        #1;
        chk("to_idle_stall", stall_out, 0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("to_idle_regwrite", RegWrite_out, 1);

        // Reset during ACCESS
        MemRead_in    = 1'b1;
        ALU_Result_in = 32'h80;
        @(negedge clk);
        #1;
        chk("rm_req_before", dmem_req, 1);
        reset_n = 1'b0;
        #1;
        chk("rm_req", dmem_req, 0);
        chk("rm_addr", dmem_addr, 0);
        chk("rm_stall", stall_out, 0);
        chk("rm_regwrite", RegWrite_out, 0);
        @(negedge clk);
        reset_n       = 1'b1;
        MemRead_in    = 1'b1;
        RegWrite_in   = 1'b1;
        ALU_Result_in = 32'h84;
        WriteReg_in   = 5'd9;
        #1;
        chk("rm_new_stall", stall_out, 1);
        @(negedge clk);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h12345678;
        #1;
        chk("rm_new_addr", dmem_addr, 32'h84);
        @(negedge clk);
        dmem_ready = 1'b0;
        clear_inputs();
        #1;
        chk("rm_new_rdata", ReadData_out, 32'h12345678);
        chk("rm_new_regwrite", RegWrite_out, 1);
        chk("rm_new_wreg", WriteReg_out, 9);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned access is rejected without a request
        MemRead_in    = 1'b1;
        RegWrite_in   = 1'b1;
        ALU_Result_in = 32'h102;
        #1;
        chk("al_stall", stall_out, 0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("al_req", dmem_req, 0);
        chk("al_buserr", bus_err_out, 1);
        chk("al_regwrite", RegWrite_out, 0);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
